vga_interval: RTL and testbench
===============================

VGA_INTERVAL -- requirements
Module: vga_interval

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front-porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back-porch pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front-porch lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back-porch lines.
REQ-009 SHALL have parameter H_SYNC_POL, default 0, asserted hsync level.
REQ-010 SHALL have parameter V_SYNC_POL, default 0, asserted vsync level.
REQ-011 SHALL have port aclk, input, 1, sole clock; all logic on rising edge.
REQ-012 SHALL have port areset, input, 1, synchronous active-high reset.
REQ-013 SHALL have port hsync, output, 1, horizontal sync at H_SYNC_POL when asserted.
REQ-014 SHALL have port vsync, output, 1, vertical sync at V_SYNC_POL when asserted.
REQ-015 SHALL have port hblank, output, 1, high outside horizontal active region.
REQ-016 SHALL have port vblank, output, 1, high outside vertical active region.
REQ-017 SHALL have port select, output, 1, high when current pixel is visible.
REQ-018 SHALL have port x, output, 12 unsigned, current horizontal position.
REQ-019 SHALL have port y, output, 12 unsigned, current vertical position.

Function
REQ-020 SHALL define H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK and V_TOTAL likewise; both SHALL be <= 4096 (elaboration error otherwise).
REQ-021 SHALL hold x and y in registers; x SHALL advance by 1 per advancing cycle, wrapping H_TOTAL-1 -> 0.
REQ-022 SHALL advance y by 1 only in the cycle x wraps; y SHALL wrap V_TOTAL-1 -> 0 when x and y wrap together.
REQ-023 SHALL order each line/frame as active, front porch, sync, back porch, starting at 0.
REQ-024 SHALL drive hblank = (x >= H_ACTIVE); vblank = (y >= V_ACTIVE).
REQ-025 SHALL assert hsync for H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC, else drive ~H_SYNC_POL.
REQ-026 SHALL assert vsync for V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC, else drive ~V_SYNC_POL.
REQ-027 SHALL drive select = ~hblank & ~vblank.
REQ-028 SHALL decode all status outputs combinationally from current x/y registers: zero latency, aligned with x/y in the same cycle.
REQ-029 SHALL never present x >= H_TOTAL or y >= V_TOTAL.

Reset
REQ-030 SHALL, on rising aclk with areset high, set x=0, y=0; outputs then hblank=0, vblank=0, select=1, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL.
REQ-031 SHALL give areset priority over advancing, including mid-line/mid-frame; counting resumes from 0,0 the first cycle after release.

Configuration
REQ-032 SHALL, when macro VGA_INTERVAL_CLKEN_EN is defined, add input port pix_ce (1 bit, after areset); counters advance only in cycles with pix_ce=1 and hold otherwise; reset ignores pix_ce.
REQ-033 SHALL, when VGA_INTERVAL_CLKEN_EN is undefined, have no pix_ce port and advance counters every non-reset cycle.

Verification
REQ-034 Reset: areset=1 for 2 cycles -> x=0, y=0, select=1, hblank=0, vblank=0, hsync=1, vsync=1 (defaults).
REQ-035 Line timing: from reset, count cycles -> hblank rises at x=640, hsync=0 for x=656..751, x wraps 799->0 with y 0->1.
REQ-036 Frame timing: run 525*800 cycles -> vblank rises at y=480, vsync=0 for y=490..491, x=799,y=524 -> next cycle x=0,y=0.
REQ-037 Mid-frame reset: pulse areset 1 cycle at x=300,y=200 -> next cycle x=0,y=0, then normal count resumes.
REQ-038 Select coverage: check select=1 exactly for x<640 and y<480 over one full frame (307200 visible cycles).
REQ-039 VGA_INTERVAL_CLKEN_EN build: pix_ce=0 for 5 cycles at x=10 -> x stays 10; pix_ce=1 -> x=11 next cycle.

Source files
------------

// File: rtl/vga_interval.sv
// Raster position counter with combinational blanking, sync and visible-pixel decode.
// Define VGA_INTERVAL_CLKEN_EN to add the pix_ce pixel-rate enable input.
module vga_interval #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0
) (
    input  logic        aclk,
    input  logic        areset,
`ifdef VGA_INTERVAL_CLKEN_EN
    input  logic        pix_ce,
`endif
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic        select,
    output logic [11:0] x,
    output logic [11:0] y
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 4096) begin : g_bad_h_total
        $error("vga_interval: H_TOTAL exceeds 4096");
    end
    if (V_TOTAL > 4096) begin : g_bad_v_total
        $error("vga_interval: V_TOTAL exceeds 4096");
    end

    // 13-bit boundaries so a 4096-wide total still compares correctly against 12-bit counters
    localparam logic [12:0] H_LAST       = 13'(H_TOTAL - 1);
    localparam logic [12:0] V_LAST       = 13'(V_TOTAL - 1);
    localparam logic [12:0] H_BLANK_FROM = 13'(H_ACTIVE);
    localparam logic [12:0] V_BLANK_FROM = 13'(V_ACTIVE);
    localparam logic [12:0] H_SYNC_FROM  = 13'(H_ACTIVE + H_FRONT);
    localparam logic [12:0] H_SYNC_TO    = 13'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [12:0] V_SYNC_FROM  = 13'(V_ACTIVE + V_FRONT);
    localparam logic [12:0] V_SYNC_TO    = 13'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        adv;
    logic [12:0] x_w, y_w;
    logic        h_sync_zone, v_sync_zone;

`ifdef VGA_INTERVAL_CLKEN_EN
    assign adv = pix_ce;
`else
    assign adv = 1'b1;
`endif

    assign x_w = {1'b0, x_q};
    assign y_w = {1'b0, y_q};

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (adv) begin
            if (x_w == H_LAST) begin
                x_d = '0;
                if (y_w == V_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + 12'd1;
                end
            end else begin
                x_d = x_q + 12'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign h_sync_zone = (x_w >= H_SYNC_FROM) && (x_w < H_SYNC_TO);
    assign v_sync_zone = (y_w >= V_SYNC_FROM) && (y_w < V_SYNC_TO);

    assign hblank = (x_w >= H_BLANK_FROM);
    assign vblank = (y_w >= V_BLANK_FROM);
    assign hsync  = h_sync_zone ? H_SYNC_POL : ~H_SYNC_POL;
    assign vsync  = v_sync_zone ? V_SYNC_POL : ~V_SYNC_POL;
    assign select = ~hblank & ~vblank;
    assign x      = x_q;
    assign y      = y_q;

endmodule

// File: tb/tb_vga_interval.sv
// Self-checking bench for vga_interval using a reduced raster so whole frames fit in a short run.
// The reference model tracks only the number of advancing cycles since reset and derives x/y by division.
module tb_vga_interval;

    localparam int unsigned HA = 20, HF = 3, HS = 5, HB = 4;
    localparam int unsigned VA = 12, VF = 2, VS = 3, VB = 2;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;
`ifdef VGA_INTERVAL_CLKEN_EN
    localparam bit HAS_CE = 1'b1;
`else
    localparam bit HAS_CE = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        pix_ce_drv = 1'b1;
    logic        hsync, vsync, hblank, vblank, select;
    logic [11:0] x, y;

    int unsigned t = 0;
    int          n_total = 0;
    int          n_bad = 0;

    always #5 aclk = ~aclk;

    vga_interval #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) dut (
        .aclk  (aclk),
        .areset(areset),
`ifdef VGA_INTERVAL_CLKEN_EN
        .pix_ce(pix_ce_drv),
`endif
        .hsync (hsync),
        .vsync (vsync),
        .hblank(hblank),
        .vblank(vblank),
        .select(select),
        .x     (x),
        .y     (y)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, got, exp, t, $time);
        end
    endtask

    // Expected outputs straight from the raster rules
    task automatic check_all();
        int unsigned ex, ey;
        bit hb, vb;
        ex = t % HT;
        ey = t / HT;
        hb = (ex >= HA);
        vb = (ey >= VA);
        check_val("x", 32'(x), ex);
        check_val("y", 32'(y), ey);
        check_val("hblank", 32'(hblank), 32'(hb));
        check_val("vblank", 32'(vblank), 32'(vb));
        check_val("select", 32'(select), 32'(!hb && !vb));
        check_val("hsync", 32'(hsync), (ex >= HA + HF && ex < HA + HF + HS) ? 0 : 1);
        check_val("vsync", 32'(vsync), (ey >= VA + VF && ey < VA + VF + VS) ? 0 : 1);
    endtask

    task automatic tick(input logic rst, input logic ce);
        areset     = rst;
        pix_ce_drv = ce;
        @(posedge aclk);
        if (rst) begin
            t = 0;
        end else if (ce || !HAS_CE) begin
            t = (t + 1) % FRAME;
        end
        #1;
        check_all();
    endtask

    task automatic run_to(input int unsigned target);
        int budget;
        budget = 2 * FRAME;
        while (t != target && budget > 0) begin
            tick(1'b0, 1'b1);
            budget--;
        end
        check_val("run_to_reached", t, target);
    endtask

    initial begin
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check_val("rst_x", 32'(x), 0);
        check_val("rst_y", 32'(y), 0);
        check_val("rst_select", 32'(select), 1);
        check_val("rst_hsync", 32'(hsync), 1);
        check_val("rst_vsync", 32'(vsync), 1);

        // Two full frames plus a line of free-running counting
        for (int i = 0; i < 2 * FRAME + HT; i++) begin
            tick(1'b0, 1'b1);
        end

        run_to(FRAME - 1);
        check_val("last_x", 32'(x), HT - 1);
        check_val("last_y", 32'(y), VT - 1);
        tick(1'b0, 1'b1);
        check_val("frame_wrap_x", 32'(x), 0);
        check_val("frame_wrap_y", 32'(y), 0);

        run_to(5 * HT + 7);
        tick(1'b1, 1'b1);
        check_val("midrst_x", 32'(x), 0);
        check_val("midrst_y", 32'(y), 0);
        for (int i = 0; i < 3 * HT; i++) begin
            tick(1'b0, 1'b1);
        end

`ifdef VGA_INTERVAL_CLKEN_EN
        tick(1'b1, 1'b0);
        run_to(10);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0);
            check_val("ce_hold_x", 32'(x), 10);
        end
        tick(1'b0, 1'b1);
        check_val("ce_resume_x", 32'(x), 11);
`endif

        for (int i = 0; i < 20000; i++) begin
            tick($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
